// File: rtl/instr_pkg.sv
// instr_pkg: command kinds, MIPS opcodes and field positions shared by the encoder and control decoder.
package instr_pkg;
   typedef enum logic [3:0] {
      K_R, K_ADDI, K_SLTIU, K_SLTI, K_LUI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_BLE, K_BLTZ, K_J
   } cmd_kind_e;
   typedef enum logic {IDLE, WRITE} state_e;
   localparam logic [5:0] OP_R     = 6'd0;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTIU = 6'd9;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_BLE   = 6'd6;
   localparam logic [5:0] OP_BLTZ  = 6'd1;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam int OP_LSB = 26;
   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;
   localparam int SH_LSB = 6;
   function automatic logic [5:0] kind_op(input logic [3:0] k);
      case (k)
         K_ADDI:  return OP_ADDI;
         K_SLTIU: return OP_SLTIU;
         K_SLTI:  return OP_SLTI;
         K_LUI:   return OP_LUI;
         K_ORI:   return OP_ORI;
         K_LW:    return OP_LW;
         K_SW:    return OP_SW;
         K_BEQ:   return OP_BEQ;
         K_BNE:   return OP_BNE;
         K_BLE:   return OP_BLE;
         K_BLTZ:  return OP_BLTZ;
         K_J:     return OP_J;
         default: return OP_R;
      endcase
   endfunction
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: command handshake and instruction-memory write port of the encoder.
interface instr_encoder_if #(parameter int ADDR_W = 8);
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic [3:0]        cmd_kind_i;
   logic [4:0]        rs_i;
   logic [4:0]        rt_i;
   logic [4:0]        rd_i;
   logic [4:0]        shamt_i;
   logic [5:0]        funct_i;
   logic [15:0]       imm_i;
   logic [25:0]       target_i;
   logic              mem_we_o;
   logic [ADDR_W+1:0] mem_addr_o;
   logic [31:0]       mem_data_o;
   logic              mem_ack_i;
   modport master (
      output cmd_valid_i, cmd_kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i, mem_ack_i,
      input  cmd_ready_o, mem_we_o, mem_addr_o, mem_data_o
   );
   modport slave (
      input  cmd_valid_i, cmd_kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i, mem_ack_i,
      output cmd_ready_o, mem_we_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational packing of a command kind and its fields into a 32-bit MIPS word.
module instr_pack
   import instr_pkg::*;
(
   input  logic [3:0]  kind_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  shamt_i,
   input  logic [5:0]  funct_i,
   input  logic [15:0] imm_i,
   input  logic [25:0] target_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);
   logic [4:0]  rs_f;
   logic [4:0]  rt_f;
   logic [31:0] low;
   always_comb begin
      illegal_o = kind_i > 4'(K_J);
      rs_f = kind_i == 4'(K_LUI) ? 5'd0 : rs_i;
      rt_f = kind_i == 4'(K_BLTZ) ? 5'd0 : rt_i;
      low = kind_i == 4'(K_J) ? 32'(target_i)
          : (32'(rs_f) << RS_LSB) | (32'(rt_f) << RT_LSB)
          | (kind_i == 4'(K_R) ? (32'(rd_i) << RD_LSB) | (32'(shamt_i) << SH_LSB) | 32'(funct_i)
                               : 32'(imm_i));
      word_o = illegal_o ? 32'd0 : (32'(kind_op(kind_i)) << OP_LSB) | low;
   end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes field-level commands into MIPS words and writes them sequentially to instruction memory.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'd0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   instr_encoder_if.slave  bus,
   output logic [ADDR_W:0] count_o,
   output logic            full_o,
   output logic            err_o
);
   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
   state_e          state_q, state_d;
   logic [31:0]     data_q, data_d;
   logic [ADDR_W:0] count_q, count_d;
   logic            err_q, err_d;
   logic [31:0]     word;
   logic            illegal, ready, acc;
   instr_pack u_pack (
      .kind_i(bus.cmd_kind_i), .rs_i(bus.rs_i), .rt_i(bus.rt_i), .rd_i(bus.rd_i),
      .shamt_i(bus.shamt_i), .funct_i(bus.funct_i), .imm_i(bus.imm_i), .target_i(bus.target_i),
      .word_o(word), .illegal_o(illegal)
   );
   // the write pointer is the word count, so the address needs no register of its own
   assign bus.mem_we_o    = state_q == WRITE;
   assign bus.mem_addr_o  = BASE_ADDR[ADDR_W+1:0] + {count_q[ADDR_W-1:0], 2'b00};
   assign bus.mem_data_o  = data_q;
   assign bus.cmd_ready_o = ready;
   assign count_o = count_q;
   assign full_o  = count_q == CAP;
   assign err_o   = err_q;
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      err_d   = err_q;
      ready = !rst_i || start_i ? 1'b0
            : state_q == IDLE ? !full_o
            : bus.mem_ack_i && (count_q + ONE < CAP);
      acc = bus.cmd_valid_i && ready;
      if (start_i) begin
         state_d = IDLE;
         count_d = '0;
         err_d   = 1'b0;
      end else begin
         if (state_q == WRITE && bus.mem_ack_i) begin
            count_d = count_q + ONE;
            state_d = IDLE;
         end
         if (acc && illegal) err_d = 1'b1;
         if (acc && !illegal) begin
            data_d  = word;
            state_d = WRITE;
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: vector table, directed corner sequences and randomized rounds against a reference model.
module tb_instr_encoder;
   localparam int AW  = 2;
   localparam int CAP = 4;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [AW:0] count;
   logic full, err;
   instr_encoder_if #(.ADDR_W(AW)) bus();
   instr_encoder #(.ADDR_W(AW), .BASE_ADDR(32'd0)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .bus(bus),
      .count_o(count), .full_o(full), .err_o(err)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0] k; logic [4:0] rs, rt, rd, sh; logic [5:0] fn;
      logic [15:0] imm; logic [25:0] tg; logic [31:0] w; logic bad;
   } vec_t;
   typedef struct { logic [31:0] addr, data; int t; } wr_t;
   wr_t wr_q[$];
   logic [31:0] exp_q[$];
   int n_run = 0, n_fail = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (rst_n && !start && bus.mem_we_o && bus.mem_ack_i)
         wr_q.push_back('{32'(bus.mem_addr_o), bus.mem_data_o, cyc});
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask
   function automatic vec_t mk(int k, int rs, int rt, int rd, int sh, int fn, int imm, int tg,
                               logic [31:0] w, logic bad);
      vec_t v;
      v.k = 4'(k); v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.sh = 5'(sh);
      v.fn = 6'(fn); v.imm = 16'(imm); v.tg = 26'(tg); v.w = w; v.bad = bad;
      return v;
   endfunction
   function automatic logic [31:0] ref_word(input vec_t c);
      int opc[13] = '{0, 8, 9, 10, 15, 13, 35, 43, 4, 5, 6, 1, 2};
      logic [31:0] base, rs, rt;
      if (c.k > 4'd12) return 32'd0;
      base = 32'(opc[c.k]) * 32'd67108864;
      rs = c.k == 4'd4 ? 32'd0 : 32'(c.rs);
      rt = c.k == 4'd11 ? 32'd0 : 32'(c.rt);
      if (c.k == 4'd12) return base + 32'(c.tg);
      if (c.k == 4'd0)
         return base + rs * 32'd2097152 + rt * 32'd65536 + 32'(c.rd) * 32'd2048
              + 32'(c.sh) * 32'd64 + 32'(c.fn);
      return base + rs * 32'd2097152 + rt * 32'd65536 + 32'(c.imm);
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic put(input vec_t c);
      bus.cmd_kind_i = c.k; bus.rs_i = c.rs; bus.rt_i = c.rt; bus.rd_i = c.rd;
      bus.shamt_i = c.sh; bus.funct_i = c.fn; bus.imm_i = c.imm; bus.target_i = c.tg;
   endtask
   task automatic send(input vec_t c);
      logic got = 1'b0;
      put(c);
      bus.cmd_valid_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.cmd_ready_o) begin
            got = 1'b1;
            break;
         end
      end
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("accept_within_budget", 32'(got), 32'd1);
   endtask
   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_q.delete();
   endtask
   vec_t v[16];
   vec_t cur;
   logic acc, exp_err;
   initial begin
      v[0]  = mk(0, 8, 9, 10, 0, 'h20, 'h1234, 'h155, 32'h01095020, 1'b0);
      v[1]  = mk(0, 0, 1, 2, 4, 0, 'hFFFF, 3, 32'h00011100, 1'b0);
      v[2]  = mk(1, 0, 8, 7, 3, 'h3F, 5, 1, 32'h20080005, 1'b0);
      v[3]  = mk(2, 2, 3, 1, 1, 1, 7, 0, 32'h24430007, 1'b0);
      v[4]  = mk(3, 2, 3, 0, 0, 0, 'h8000, 0, 32'h28438000, 1'b0);
      v[5]  = mk(4, 5, 3, 9, 9, 9, 'h1234, 0, 32'h3C031234, 1'b0);
      v[6]  = mk(5, 1, 2, 0, 0, 0, 'hFFFF, 0, 32'h3422FFFF, 1'b0);
      v[7]  = mk(6, 29, 8, 0, 0, 0, 4, 0, 32'h8FA80004, 1'b0);
      v[8]  = mk(7, 29, 31, 0, 0, 0, 8, 0, 32'hAFBF0008, 1'b0);
      v[9]  = mk(8, 1, 2, 0, 0, 0, 3, 0, 32'h10220003, 1'b0);
      v[10] = mk(9, 1, 2, 0, 0, 0, 'hFFFF, 0, 32'h1422FFFF, 1'b0);
      v[11] = mk(10, 6, 9, 0, 0, 0, 2, 0, 32'h18C90002, 1'b0);
      v[12] = mk(11, 4, 7, 0, 0, 0, 'hFFFE, 0, 32'h0480FFFE, 1'b0);
      v[13] = mk(12, 31, 31, 31, 31, 'h3F, 'hFFFF, 'h3FFFFFF, 32'h0BFFFFFF, 1'b0);
      v[14] = mk(13, 1, 2, 3, 4, 5, 6, 7, 32'd0, 1'b1);
      v[15] = mk(15, 1, 2, 3, 4, 5, 6, 7, 32'd0, 1'b1);
      put(v[2]);
      bus.cmd_valid_i = 1'b1;
      bus.mem_ack_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_we", 32'(bus.mem_we_o), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr_o), 32'd0);
      chk("rst_data", bus.mem_data_o, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(bus.cmd_ready_o), 32'd0);
      tick();
      rst_n = 1'b1;
      bus.cmd_valid_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         pulse_start();
         bus.mem_ack_i = 1'b1;
         send(v[i]);
         repeat (2) tick();
         chk($sformatf("vec%0d_nwrites", i), 32'(wr_q.size()), v[i].bad ? 32'd0 : 32'd1);
         if (wr_q.size() > 0) begin
            chk($sformatf("vec%0d_word", i), wr_q[0].data, v[i].w);
            chk($sformatf("vec%0d_addr", i), wr_q[0].addr, 32'd0);
         end
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(v[i].bad));
         chk($sformatf("vec%0d_count", i), 32'(count), v[i].bad ? 32'd0 : 32'd1);
      end
      pulse_start();
      bus.mem_ack_i = 1'b1;
      send(mk(1, 0, 8, 0, 0, 0, 5, 0, 32'd0, 1'b0));
      @(negedge clk);
      chk("t1_we", 32'(bus.mem_we_o), 32'd1);
      chk("t1_data", bus.mem_data_o, 32'h20080005);
      chk("t1_addr", 32'(bus.mem_addr_o), 32'd0);
      chk("t1_count_before_ack", 32'(count), 32'd0);
      tick();
      chk("t1_count", 32'(count), 32'd1);
      chk("t1_we_low", 32'(bus.mem_we_o), 32'd0);
      bus.mem_ack_i = 1'b0;
      send(mk(0, 8, 9, 10, 0, 'h20, 0, 0, 32'd0, 1'b0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_we_held", 32'(bus.mem_we_o), 32'd1);
         chk("t2_data_held", bus.mem_data_o, 32'h01095020);
         chk("t2_addr_held", 32'(bus.mem_addr_o), 32'h4);
         chk("t2_count_held", 32'(count), 32'd1);
         tick();
      end
      bus.mem_ack_i = 1'b1;
      @(negedge clk);
      chk("t2_data_ack", bus.mem_data_o, 32'h01095020);
      chk("t2_addr_ack", 32'(bus.mem_addr_o), 32'h4);
      tick();
      bus.mem_ack_i = 1'b0;
      chk("t2_count", 32'(count), 32'd2);
      chk("t2_nwrites", 32'(wr_q.size()), 32'd2);
      pulse_start();
      bus.mem_ack_i = 1'b1;
      send(mk(11, 4, 7, 0, 0, 0, 'hFFFE, 0, 32'd0, 1'b0));
      send(mk(12, 0, 0, 0, 0, 0, 0, 'h10, 32'd0, 1'b0));
      repeat (2) tick();
      chk("t3_nwrites", 32'(wr_q.size()), 32'd2);
      if (wr_q.size() == 2) begin
         chk("t3_w0", wr_q[0].data, 32'h0480FFFE);
         chk("t3_a0", wr_q[0].addr, 32'h0);
         chk("t3_w1", wr_q[1].data, 32'h08000010);
         chk("t3_a1", wr_q[1].addr, 32'h4);
         chk("t3_b2b", 32'(wr_q[1].t - wr_q[0].t), 32'd1);
      end
      pulse_start();
      send(mk(6, 29, 8, 0, 0, 0, 4, 0, 32'd0, 1'b0));
      send(mk(14, 1, 1, 1, 1, 1, 1, 1, 32'd0, 1'b1));
      repeat (2) tick();
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_count", 32'(count), 32'd1);
      chk("t4_nwrites", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) chk("t4_word", wr_q[0].data, 32'h8FA80004);
      pulse_start();
      for (int i = 0; i < 4; i++) send(mk(1, 1, 2, 0, 0, 0, i, 0, 32'd0, 1'b0));
      repeat (2) tick();
      chk("t5_full", 32'(full), 32'd1);
      chk("t5_count", 32'(count), 32'd4);
      put(mk(5, 1, 1, 0, 0, 0, 1, 0, 32'd0, 1'b0));
      bus.cmd_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_stall_ready", 32'(bus.cmd_ready_o), 32'd0);
         tick();
      end
      bus.cmd_valid_i = 1'b0;
      chk("t5_nwrites", 32'(wr_q.size()), 32'd4);
      if (wr_q.size() == 4) chk("t5_last_addr", wr_q[3].addr, 32'hC);
      pulse_start();
      chk("t5_start_count", 32'(count), 32'd0);
      chk("t5_start_full", 32'(full), 32'd0);
      send(mk(1, 0, 8, 0, 0, 0, 5, 0, 32'd0, 1'b0));
      tick();
      chk("t5_restart_nwrites", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) chk("t5_restart_addr", wr_q[0].addr, 32'd0);
      pulse_start();
      send(mk(1, 0, 8, 0, 0, 0, 5, 0, 32'd0, 1'b0));
      send(mk(13, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b1));
      bus.mem_ack_i = 1'b0;
      send(mk(1, 0, 9, 0, 0, 0, 9, 0, 32'd0, 1'b0));
      @(negedge clk);
      chk("t6s_we_pending", 32'(bus.mem_we_o), 32'd1);
      chk("t6s_err_before", 32'(err), 32'd1);
      tick();
      start = 1'b1;
      bus.mem_ack_i = 1'b1;
      put(mk(5, 1, 1, 0, 0, 0, 1, 0, 32'd0, 1'b0));
      bus.cmd_valid_i = 1'b1;
      @(negedge clk);
      chk("t6s_ready_in_start", 32'(bus.cmd_ready_o), 32'd0);
      tick();
      start = 1'b0;
      bus.mem_ack_i = 1'b0;
      bus.cmd_valid_i = 1'b0;
      @(negedge clk);
      chk("t6s_we", 32'(bus.mem_we_o), 32'd0);
      chk("t6s_count", 32'(count), 32'd0);
      chk("t6s_err", 32'(err), 32'd0);
      chk("t6s_nwrites", 32'(wr_q.size()), 32'd1);
      tick();
      bus.mem_ack_i = 1'b1;
      send(mk(1, 0, 8, 0, 0, 0, 5, 0, 32'd0, 1'b0));
      send(mk(15, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b1));
      tick();
      bus.mem_ack_i = 1'b0;
      send(mk(1, 0, 9, 0, 0, 0, 9, 0, 32'd0, 1'b0));
      @(negedge clk);
      chk("t6r_we_pending", 32'(bus.mem_we_o), 32'd1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6r_we", 32'(bus.mem_we_o), 32'd0);
      chk("t6r_count", 32'(count), 32'd0);
      chk("t6r_err", 32'(err), 32'd0);
      chk("t6r_ready", 32'(bus.cmd_ready_o), 32'd0);
      chk("t6r_addr", 32'(bus.mem_addr_o), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int r = 0; r < 6; r++) begin
         pulse_start();
         exp_q.delete();
         exp_err = 1'b0;
         acc = 1'b0;
         for (int c = 0; c < 40; c++) begin
            tick();
            if (acc) bus.cmd_valid_i = 1'b0;
            if (!bus.cmd_valid_i && $urandom_range(1, 0) == 1) begin
               cur = mk($urandom_range(15, 0), $urandom_range(31, 0), $urandom_range(31, 0),
                        $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(63, 0),
                        $urandom_range(65535, 0), $urandom_range(67108863, 0), 32'd0, 1'b0);
               put(cur);
               bus.cmd_valid_i = 1'b1;
            end
            bus.mem_ack_i = $urandom_range(1, 0) == 1;
            @(negedge clk);
            acc = bus.cmd_valid_i && bus.cmd_ready_o;
            if (acc && cur.k > 4'd12) exp_err = 1'b1;
            if (acc && cur.k <= 4'd12) begin
               chk("rnd_accept_below_cap", 32'(exp_q.size() < CAP), 32'd1);
               exp_q.push_back(ref_word(cur));
            end
         end
         tick();
         bus.cmd_valid_i = 1'b0;
         bus.mem_ack_i = 1'b1;
         repeat (3) tick();
         chk("rnd_nwrites", 32'(wr_q.size()), 32'(exp_q.size()));
         for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            chk("rnd_word", wr_q[i].data, exp_q[i]);
            chk("rnd_addr", wr_q[i].addr, 32'(4 * i));
         end
         chk("rnd_count", 32'(count), 32'(exp_q.size()));
         chk("rnd_full", 32'(full), 32'(exp_q.size() == CAP));
         chk("rnd_err", 32'(err), 32'(exp_err));
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Produces 32-bit MIPS instruction words from field-level commands and writes them sequentially into instruction memory over a write/ack handshake.
- Acts as the inverse of the control decoder: it emits exactly the opcode set the CPU decodes.
- Used by the test harness and the boot loader to build programs in instruction memory before the CPU is released from reset.

Parameters:
- ADDR_W, 8, word-address width of instruction memory; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, byte address of the first written word; must be word-aligned.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  synchronous restart: clears write pointer and error.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid and ready are both high.
- cmd_kind_i  in  4  0 R, 1 ADDI, 2 SLTIU, 3 SLTI, 4 LUI, 5 ORI, 6 LW, 7 SW, 8 BEQ, 9 BNE, 10 BLE, 11 BLTZ, 12 J; 13-15 illegal.
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register/shift fields.
- funct_i  in  6  R-type function.
- imm_i  in  16  immediate/offset.
- target_i  in  26  jump target.
- mem_we_o  out  1  write request, held until acked.
- mem_addr_o  out  ADDR_W+2  byte address.
- mem_data_o  out  32  encoded word.
- mem_ack_i  in  1  memory accepts the write this cycle.
- count_o  out  ADDR_W+1  words written since start/reset.
- full_o  out  1  count_o == 2^ADDR_W.
- err_o  out  1  sticky: an illegal kind was received.

Behaviour:
- Reset (rst_i low, async): state IDLE.
  - mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0.
  - count_o=0, full_o=0, err_o=0, cmd_ready_o=0 while in reset.
- Opcodes: R 0, ADDI 8, SLTIU 9, SLTI 10, LUI 15, ORI 13, LW 35, SW 43, BEQ 4, BNE 5, BLE 6, BLTZ 1, J 2.
- Encoding:
  - R-type: {op, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm}.
  - LUI forces rs=0.
  - BLTZ forces rt=0.
  - J: {op, target}.
  - Fields not used by a kind are ignored.
- FSM states: IDLE, WRITE.
  - IDLE: cmd_ready_o = !full_o.
    - Accepting a legal kind registers the word and address and moves to WRITE; mem_we_o rises the next cycle (latency 1).
    - Accepting an illegal kind consumes the command, sets err_o, writes nothing, leaves count unchanged and stays in IDLE.
  - WRITE: mem_we_o=1; addr and data are stable until ack.
    - On mem_ack_i, count increments, and mem_addr_o advances by 4 for the next word.
    - cmd_ready_o = mem_ack_i && (count_o+1 < 2^ADDR_W), a combinational pass-through. A command accepted in the ack cycle stays in WRITE with the new word, giving back-to-back writes at 1 word/cycle.
    - On ack with no new command, go to IDLE.
- Full: when count reaches 2^ADDR_W, full_o=1 and cmd_ready_o=0. There is no wrap; further commands stall.
- start_i has priority over everything:
  - Next cycle: state IDLE, mem_we_o=0, count=0, err_o=0, address=BASE_ADDR.
  - A pending unacked write is abandoned.
  - An ack coinciding with start_i is not counted.
  - cmd_ready_o=0 in the start_i cycle.
- mem_ack_i while mem_we_o=0 is ignored.
- Reset mid-write: the write is dropped immediately (mem_we_o low asynchronously).

Decomposition:
- Package instr_pkg:
  - cmd_kind enum (values above).
  - 6-bit opcode constants, shared with the control decoder's case labels.
  - Field bit-position constants.
- Sub-module instr_pack: purely combinational kind+fields -> {word, illegal}. The parent holds the FSM, pointer and handshake.

Test Plan:
1. ADDI rs=0 rt=8 imm=5, ack immediately -> mem_we_o high 1 cycle after accept, mem_data_o=0x20080005, mem_addr_o=0x000, count_o=1.
2. R rs=8 rt=9 rd=10 shamt=0 funct=0x20, ack withheld 3 cycles -> data 0x01095020 and addr 0x004 held stable for all 4 cycles, count_o increments only on ack.
3. Back-to-back BLTZ rs=4 rt_i=7 imm=0xFFFE then J target=0x10 with ack every cycle -> words 0x0480FFFE at 0x000 and 0x08000010 at 0x004 on consecutive cycles.
4. LW rs=29 rt=8 imm=4, then kind=14 -> word 0x8FA80004 written; err_o=1 after the illegal command; count_o stays 1; no second write.
5. ADDR_W=2: 4 writes -> full_o=1, cmd_ready_o=0 with cmd_valid_i high; start_i -> count_o=0, full_o=0, next write at BASE_ADDR.
6. start_i (and separately rst_i low) asserted during an unacked write -> mem_we_o low next cycle (immediately for reset), count_o=0, err_o=0.
